router_dst_fifo: RTL

- Per-destination output buffer of the 1x3 router; one instance per output port.
- Accepts packet bytes from the router write path and presents them to the destination agent on the data_out / vld_out / read_enb handshake.
- Flushes itself (soft reset) when the destination does not drain a valid byte within a timeout window.
- Tracks packet boundaries from the header byte to flag the last (parity) byte.

---
 rtl/router_dst_fifo.sv | 130 +++++++++++++
 1 files changed

// File: rtl/router_dst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : router_dst_fifo
//  Description : Per-destination output buffer of the 1x3 router. A
//                circular FIFO with wrap-bit pointers. It has a registered
//                read port and tracks packet length from the header byte so
//                that it can flag the parity byte. It flushes itself when a
//                valid byte waits too long without being read.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_dst_fifo #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enb,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lfd_state,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             full,
    output logic             empty,
    output logic             soft_reset,
    output logic             pkt_end
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_TW    = $clog2(TIMEOUT) + 1;
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT - 1);

    // Each entry carries the header marker above the data byte
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [5:0]       r_pkt_cnt;
    logic [c_TW-1:0]  r_tcnt;

    logic             w_empty;
    logic             w_full;
    logic             w_idle;
    logic             w_flush;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [WIDTH:0]   w_rd_word;

    // Equal pointers mean empty; the same slot with opposite laps means full
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty     = w_empty;
    assign full      = w_full;
    assign vld_out   = !w_empty;

    // A valid byte is waiting and the destination is not reading it
    assign w_idle    = !w_empty && !read_enb;
    assign w_flush   = w_idle && (r_tcnt == c_TLAST);
    assign w_wr_fire = write_enb && !w_full && !w_flush;
    assign w_rd_fire = read_enb && !w_empty;
    assign w_rd_word = r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage array: the array is not reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {lfd_state, data_in};
        end
    end

    // Write and read pointers; a flush rewinds both to the origin
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Timeout counter of consecutive cycles where a valid byte is left unread
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tcnt <= '0;
        end else if (!w_idle || w_flush) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + c_TW'(1);
        end
    end

    // Registered read data plus packet-length tracking for the parity-byte flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out  <= '0;
            r_pkt_cnt <= '0;
            pkt_end   <= 1'b0;
        end else begin
            pkt_end <= 1'b0;
            if (w_flush) begin
                data_out  <= '0;
                r_pkt_cnt <= '0;
            end else if (w_rd_fire) begin
                data_out <= w_rd_word[WIDTH-1:0];
                if (w_rd_word[WIDTH]) begin
                    // A header restarts the count even if a packet was cut short
                    r_pkt_cnt <= w_rd_word[7:2] + 6'd1;
                end else if (r_pkt_cnt != 6'd0) begin
                    r_pkt_cnt <= r_pkt_cnt - 6'd1;
                    pkt_end   <= (r_pkt_cnt == 6'd1);
                end
            end
        end
    end

    // One-cycle soft-reset pulse that marks a timeout flush
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= w_flush;
        end
    end

endmodule
`default_nettype wire
